// File: rtl/encoder_fec_pkg.sv
// Shared types and constants for the FEC Hamming encoder path
// and the arbiter that multiplexes message sources onto it.
package encoder_fec_pkg;

   typedef logic [7:0]  message_data_t;
   typedef logic [15:0] encoded_message_data_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DELIVER
   } arb_state_t;

   localparam int ENC_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request searching
// upward from last_grant+1, wrapping at NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     grant_idx,
   output logic               any_valid
);

   int             cand;
   logic [IDW-1:0] cidx;

   // The last offset tried is last_grant itself, so a lone requester can win twice in a row.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      cand      = 0;
      cidx      = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = (int'(last_grant) + off) % NUM_REQ;
         cidx = IDW'(cand);
         if (!any_valid && req[cidx]) begin
            any_valid   = 1'b1;
            grant_idx   = cidx;
            grant[cidx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/encoder_arbiter.sv
// Shares one Hamming encoder between NUM_REQ message sources: accepts one
// message at a time, issues it, captures the codeword and returns it tagged.
module encoder_arbiter
   import encoder_fec_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = ENC_TIMEOUT_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           in_valid,
   input  message_data_t [NUM_REQ-1:0]  in_data,
   output logic [NUM_REQ-1:0]           in_ready,
   output logic                         enc_en,
   output logic                         enc_req,
   output message_data_t                enc_data,
   input  logic                         enc_ack,
   input  encoded_message_data_t        enc_data_out,
   output logic                         out_valid,
   output logic [$clog2(NUM_REQ)-1:0]   out_id,
   output encoded_message_data_t        out_data,
   input  logic                         out_ready,
   output logic                         err_timeout
);

   localparam int IDW = $clog2(NUM_REQ);

   arb_state_t            state_q, state_d;
   logic [IDW-1:0]        last_grant_q, last_grant_d;
   message_data_t         msg_q, msg_d;
   logic [IDW-1:0]        id_q, id_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  out_valid_q, out_valid_d;
   encoded_message_data_t out_data_q, out_data_d;
   logic [IDW-1:0]        out_id_q, out_id_d;
   logic                  err_q, err_d;

   logic [NUM_REQ-1:0]    grant;
   logic [IDW-1:0]        grant_idx;
   logic                  any_valid;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr_arbiter (
      .req        (in_valid),
      .last_grant (last_grant_q),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .any_valid  (any_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= IDW'(NUM_REQ - 1);
         msg_q        <= '0;
         id_q         <= '0;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_id_q     <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         msg_q        <= msg_d;
         id_q         <= id_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_id_q     <= out_id_d;
         err_q        <= err_d;
      end
   end

   // An ack arriving in the same cycle the count expires takes priority over the abort.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      msg_d        = msg_q;
      id_d         = id_q;
      cnt_d        = cnt_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_id_d     = out_id_q;
      err_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               msg_d        = in_data[grant_idx];
               id_d         = grant_idx;
               last_grant_d = grant_idx;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (enc_ack) begin
               out_data_d  = enc_data_out;
               out_id_d    = id_q;
               out_valid_d = 1'b1;
               state_d     = DELIVER;
            end else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DELIVER: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == IDLE) ? grant : '0;
      enc_en   = (state_q == ISSUE);
      enc_req  = (state_q == ISSUE);
   end

   assign enc_data    = msg_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_id      = out_id_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_encoder_arbiter.sv
// Self-checking bench for encoder_arbiter with a behavioural Hamming(12,8)+parity
// encoder stub whose acknowledge latency can be changed per message.
module tb_encoder_arbiter;

   localparam int NREQ = 4;
   localparam int TMO  = 3;

   logic             clk;
   logic             rst_n;
   logic [3:0]       inValid;
   logic [3:0][7:0]  inData;
   logic [3:0]       inReady;
   logic             encEn;
   logic             encReq;
   logic [7:0]       encData;
   logic             encAck;
   logic [15:0]      encDataOut;
   logic             outValid;
   logic [1:0]       outId;
   logic [15:0]      outData;
   logic             outReady;
   logic             errTimeout;

   int checks = 0;
   int errors = 0;
   int ackDelay = 1;
   int pendCnt;
   logic [15:0] pendData;

   encoder_arbiter #(
      .NUM_REQ (NREQ),
      .TIMEOUT (TMO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (inValid),
      .in_data      (inData),
      .in_ready     (inReady),
      .enc_en       (encEn),
      .enc_req      (encReq),
      .enc_data     (encData),
      .enc_ack      (encAck),
      .enc_data_out (encDataOut),
      .out_valid    (outValid),
      .out_id       (outId),
      .out_data     (outData),
      .out_ready    (outReady),
      .err_timeout  (errTimeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hamming(12,8): data at positions 3,5,6,7,9,10,11,12, parity at 1,2,4,8, overall parity at bit 0.
   function automatic logic [15:0] hamming(input logic [7:0] m);
      int pos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
      logic [15:0] cw;
      logic par;
      cw = '0;
      for (int i = 0; i < 8; i++) cw[pos[i]] = m[i];
      for (int p = 1; p <= 8; p = p * 2) begin
         par = 1'b0;
         for (int j = 3; j <= 12; j++)
            if (((j & p) != 0) && (j != p)) par = par ^ cw[j];
         cw[p] = par;
      end
      cw[0] = ^cw[12:1];
      return cw;
   endfunction

   function automatic int rrPick(input logic [3:0] v, input int last);
      for (int off = 1; off <= NREQ; off++) begin
         int c;
         c = (last + off) % NREQ;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   // Encoder stub: ackDelay=1 models the real encoder (ack one cycle after req), 0 never acks.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         encAck     <= 1'b0;
         encDataOut <= '0;
         pendCnt    <= 0;
         pendData   <= '0;
      end else begin
         encAck <= 1'b0;
         if (encReq) begin
            if (ackDelay == 1) begin
               encAck     <= 1'b1;
               encDataOut <= hamming(encData);
               pendCnt    <= 0;
            end else begin
               pendCnt  <= (ackDelay == 0) ? 0 : ackDelay - 1;
               pendData <= hamming(encData);
            end
         end else if (pendCnt > 0) begin
            pendCnt <= pendCnt - 1;
            if (pendCnt == 1) begin
               encAck     <= 1'b1;
               encDataOut <= pendData;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // One cycle: drive inputs at the falling edge, then let combinational outputs settle.
   task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic rdy);
      @(negedge clk);
      inValid  = v;
      inData   = d;
      outReady = rdy;
      #1;
   endtask

   task automatic doReset();
      rst_n    = 1'b0;
      inValid  = '0;
      inData   = '0;
      outReady = 1'b0;
      ackDelay = 1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic waitOutValid(input logic rdy, output int found, output int reqCount);
      found    = 0;
      reqCount = 0;
      for (int k = 0; k < 15 && found == 0; k++) begin
         applyStimulus(4'b0000, 32'h0, rdy);
         if (encReq) reqCount++;
         if (outValid) found = 1;
      end
   endtask

   typedef struct {
      logic [3:0]  valid;
      logic [7:0]  data;
      int          expId;
      logic [15:0] expCode;
   } vec_t;

   vec_t vecs [7];

   int found, reqCount, errCount, errCycle, ovSeen;
   logic [3:0] readyAtErr;

   int mBusy, mT, mId, mLast, mDelay, mErrCyc, g;
   logic [7:0] mMsg;
   int delayChoices [5] = '{0, 1, 2, 3, 5};

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{4'b1111, 8'hFF, 0, 16'h1EEE};
      vecs[1] = '{4'b1111, 8'hFF, 1, 16'h1EEE};
      vecs[2] = '{4'b1111, 8'hFF, 2, 16'h1EEE};
      vecs[3] = '{4'b1111, 8'hFF, 3, 16'h1EEE};
      vecs[4] = '{4'b0100, 8'h80, 2, 16'h1111};
      vecs[5] = '{4'b1001, 8'h02, 3, 16'h0033};
      vecs[6] = '{4'b1001, 8'h01, 0, 16'h000F};

      // Reset state
      doReset();
      #1;
      checkOutput("reset out_valid", 32'(outValid), 32'h0);
      checkOutput("reset out_data", 32'(outData), 32'h0);
      checkOutput("reset enc_req", 32'(encReq), 32'h0);
      checkOutput("reset err_timeout", 32'(errTimeout), 32'h0);

      // Single message with exact cycle latency
      applyStimulus(4'b0001, 32'h0000_0001, 1'b1);
      checkOutput("single c0 in_ready", 32'(inReady), 32'h1);
      applyStimulus(4'b0000, 32'h0, 1'b1);
      checkOutput("single c1 enc_req", 32'(encReq), 32'h1);
      checkOutput("single c1 enc_en", 32'(encEn), 32'h1);
      checkOutput("single c1 enc_data", 32'(encData), 32'h01);
      applyStimulus(4'b0000, 32'h0, 1'b1);
      checkOutput("single c2 enc_req", 32'(encReq), 32'h0);
      checkOutput("single c2 out_valid", 32'(outValid), 32'h0);
      applyStimulus(4'b0000, 32'h0, 1'b1);
      checkOutput("single c3 out_valid", 32'(outValid), 32'h1);
      checkOutput("single c3 out_data", 32'(outData), 32'h000F);
      checkOutput("single c3 out_id", 32'(outId), 32'h0);
      applyStimulus(4'b0000, 32'h0, 1'b1);
      checkOutput("single c4 out_valid", 32'(outValid), 32'h0);

      // Back-pressure: other sources stay valid while the codeword is held
      applyStimulus(4'b1110, {4{8'hFF}}, 1'b0);
      checkOutput("bp grant", 32'(inReady), 32'b0010);
      found = 0;
      for (int k = 0; k < 15 && found == 0; k++) begin
         applyStimulus(4'b1110, {4{8'hFF}}, 1'b0);
         if (outValid) found = 1;
      end
      checkOutput("bp out_valid seen", 32'(found), 32'h1);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(4'b1110, {4{8'hFF}}, 1'b0);
         checkOutput("bp held out_valid", 32'(outValid), 32'h1);
         checkOutput("bp held out_data", 32'(outData), 32'h1EEE);
         checkOutput("bp held out_id", 32'(outId), 32'h1);
         checkOutput("bp in_ready", 32'(inReady), 32'h0);
         checkOutput("bp enc_req", 32'(encReq), 32'h0);
      end
      applyStimulus(4'b1110, {4{8'hFF}}, 1'b1);
      checkOutput("bp release out_valid", 32'(outValid), 32'h1);
      applyStimulus(4'b1110, {4{8'hFF}}, 1'b1);
      checkOutput("bp resume out_valid", 32'(outValid), 32'h0);
      checkOutput("bp resume grant", 32'(inReady), 32'b0100);

      // Contention and fairness-after-idle table
      doReset();
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].valid, {4{vecs[i].data}}, 1'b1);
         checkOutput($sformatf("vec%0d in_ready", i), 32'(inReady), 32'(1 << vecs[i].expId));
         waitOutValid(1'b1, found, reqCount);
         checkOutput($sformatf("vec%0d out_valid", i), 32'(found), 32'h1);
         checkOutput($sformatf("vec%0d enc_req count", i), 32'(reqCount), 32'h1);
         checkOutput($sformatf("vec%0d out_id", i), 32'(outId), 32'(vecs[i].expId));
         checkOutput($sformatf("vec%0d out_data", i), 32'(outData), 32'(vecs[i].expCode));
      end

      // Timeout with a silent encoder; source 1 waits behind source 2
      doReset();
      ackDelay = 0;
      applyStimulus(4'b0100, {4{8'h55}}, 1'b1);
      checkOutput("tmo grant", 32'(inReady), 32'b0100);
      errCount   = 0;
      errCycle   = -1;
      ovSeen     = 0;
      readyAtErr = '0;
      for (int k = 1; k <= 8; k++) begin
         applyStimulus((k <= 5) ? 4'b0010 : 4'b0000, {4{8'h66}}, 1'b1);
         if (outValid) ovSeen = 1;
         if (errTimeout) begin
            errCount++;
            if (errCycle < 0) begin
               errCycle   = k;
               readyAtErr = inReady;
            end
         end
      end
      checkOutput("tmo err pulses", 32'(errCount), 32'h1);
      checkOutput("tmo err cycle", 32'(errCycle), 32'(TMO + 2));
      checkOutput("tmo no out_valid", 32'(ovSeen), 32'h0);
      checkOutput("tmo next grant", 32'(readyAtErr), 32'b0010);

      // Asynchronous reset in the cycle after ISSUE
      doReset();
      applyStimulus(4'b0100, {4{8'h80}}, 1'b1);
      waitOutValid(1'b1, found, reqCount);
      applyStimulus(4'b0000, 32'h0, 1'b1);
      ackDelay = 3;
      applyStimulus(4'b0010, {4{8'h5A}}, 1'b1);
      checkOutput("rst pre grant", 32'(inReady), 32'b0010);
      applyStimulus(4'b0000, 32'h0, 1'b1);
      checkOutput("rst pre issue", 32'(encReq), 32'h1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst out_valid", 32'(outValid), 32'h0);
      checkOutput("rst out_data", 32'(outData), 32'h0);
      checkOutput("rst out_id", 32'(outId), 32'h0);
      checkOutput("rst err_timeout", 32'(errTimeout), 32'h0);
      checkOutput("rst enc_req", 32'(encReq), 32'h0);
      checkOutput("rst enc_en", 32'(encEn), 32'h0);
      checkOutput("rst enc_data", 32'(encData), 32'h0);
      checkOutput("rst in_ready", 32'(inReady), 32'h0);
      @(negedge clk);
      rst_n    = 1'b1;
      ackDelay = 1;
      applyStimulus(4'b1111, {4{8'h01}}, 1'b1);
      checkOutput("rst first grant", 32'(inReady), 32'b0001);
      waitOutValid(1'b1, found, reqCount);
      checkOutput("rst first out_id", 32'(outId), 32'h0);

      // Randomized traffic against a transaction-timeline reference model
      doReset();
      mBusy   = 0;
      mT      = 0;
      mId     = 0;
      mMsg    = '0;
      mLast   = NREQ - 1;
      mDelay  = 1;
      mErrCyc = -1;
      for (int c = 0; c < 400; c++) begin
         applyStimulus(4'(($urandom & $urandom) & 32'hF), $urandom, 1'($urandom_range(0, 1)));
         if (mBusy == 0) begin
            g = rrPick(inValid, mLast);
            checkOutput("rnd in_ready", 32'(inReady), (g >= 0) ? 32'(1 << g) : 32'h0);
            checkOutput("rnd idle out_valid", 32'(outValid), 32'h0);
            checkOutput("rnd idle enc_req", 32'(encReq), 32'h0);
            checkOutput("rnd err_timeout", 32'(errTimeout), 32'(c == mErrCyc));
            if (g >= 0) begin
               mBusy    = 1;
               mT       = c;
               mId      = g;
               mMsg     = inData[2'(g)];
               mLast    = g;
               mDelay   = delayChoices[$urandom_range(0, 4)];
               ackDelay = mDelay;
            end
         end else begin
            checkOutput("rnd busy in_ready", 32'(inReady), 32'h0);
            checkOutput("rnd enc_req", 32'(encReq), 32'(c == mT + 1));
            checkOutput("rnd enc_en", 32'(encEn), 32'(c == mT + 1));
            checkOutput("rnd enc_data", 32'(encData), 32'(mMsg));
            checkOutput("rnd busy err_timeout", 32'(errTimeout), 32'h0);
            if (mDelay >= 1 && mDelay <= TMO) begin
               checkOutput("rnd out_valid", 32'(outValid), 32'(c >= mT + 2 + mDelay));
               if (c >= mT + 2 + mDelay) begin
                  checkOutput("rnd out_data", 32'(outData), 32'(hamming(mMsg)));
                  checkOutput("rnd out_id", 32'(outId), 32'(mId));
                  if (outReady) mBusy = 0;
               end
            end else begin
               checkOutput("rnd tmo out_valid", 32'(outValid), 32'h0);
               if (c == mT + 1 + TMO) begin
                  mBusy   = 0;
                  mErrCyc = c + 1;
               end
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
